// File: rtl/mult_array_pipe_if.sv
// Valid/ready operand and result channels for the pipelined array multiplier.
// The bench drives through the master modport; the multiplier uses the slave modport.
interface mult_array_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   y;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/mult_array_pipe.sv
// Pipelined array multiplier: an input register, then one adder stage per group of
// ROWS_PER_STAGE partial-product rows, then an output register; the whole pipe stalls together.
module mult_array_pipe #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_array_pipe_if.slave  bus
);
  localparam int STAGES = WIDTH / ROWS_PER_STAGE;
  localparam int PW     = 2 * WIDTH;

  generate
    if (WIDTH < 2 || WIDTH > 32 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_bad_cfg
      $error("mult_array_pipe: illegal WIDTH/ROWS_PER_STAGE combination");
    end
  endgenerate

  // Row j of the array: b (zero- or sign-extended) shifted by j, gated by a[j].
  // In signed mode the MSB row of a carries negative weight, so it is subtracted.
  function automatic logic signed [PW-1:0] pp_row(input logic [WIDTH-1:0] av,
                                                  input logic [WIDTH-1:0] bv,
                                                  input logic             mode,
                                                  input int               j);
    logic [WIDTH-1:0]     abit;
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] row;
    abit = av >> j;
    bx   = {{WIDTH{mode & bv[WIDTH-1]}}, bv};
    row  = bx <<< j;
    if (!abit[0])
      return '0;
    else if (mode && j == WIDTH - 1)
      return -row;
    else
      return row;
  endfunction

  logic                 vld_q  [0:STAGES];
  logic signed [PW-1:0] acc_q  [0:STAGES];
  logic [WIDTH-1:0]     a_q    [0:STAGES-1];
  logic [WIDTH-1:0]     b_q    [0:STAGES-1];
  logic                 mode_q [0:STAGES-1];
  logic                 out_vld_q;
  logic [PW-1:0]        y_q;
  logic signed [PW-1:0] acc_d  [1:STAGES];
  logic                 stall;

  assign stall         = out_vld_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_vld_q;
  assign bus.y         = y_q;

  always_comb begin
    for (int s = 1; s <= STAGES; s++) begin
      acc_d[s] = acc_q[s-1];
      for (int r = 0; r < ROWS_PER_STAGE; r++)
        acc_d[s] = acc_d[s] + pp_row(a_q[s-1], b_q[s-1], mode_q[s-1], (s-1)*ROWS_PER_STAGE + r);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) begin
        vld_q[s] <= 1'b0;
        acc_q[s] <= '0;
      end
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]    <= '0;
        b_q[s]    <= '0;
        mode_q[s] <= 1'b0;
      end
      out_vld_q <= 1'b0;
      y_q       <= '0;
    end else if (!stall) begin
      // input register
      vld_q[0]  <= bus.in_valid;
      a_q[0]    <= bus.a;
      b_q[0]    <= bus.b;
      mode_q[0] <= bus.signed_mode;
      acc_q[0]  <= '0;
      // adder stages 1..STAGES
      for (int s = 1; s <= STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        acc_q[s] <= acc_d[s];
      end
      for (int s = 1; s < STAGES; s++) begin
        a_q[s]    <= a_q[s-1];
        b_q[s]    <= b_q[s-1];
        mode_q[s] <= mode_q[s-1];
      end
      // output register; y keeps its last product across bubbles
      out_vld_q <= vld_q[STAGES];
      if (vld_q[STAGES])
        y_q <= acc_q[STAGES];
    end
  end
endmodule
